// File: rtl/parking_pkg.sv
// Shared types and sensor encodings for the parking lane controller.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENT_A,
    ST_ENT_AB,
    ST_ENT_B,
    ST_EXT_B,
    ST_EXT_AB,
    ST_EXT_A,
    ST_RESYNC
  } lane_state_e;

  // Sensor pair encoding {A (outer), B (inner)}, 1 = beam blocked
  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_A    = 2'b10;
  localparam logic [1:0] S_AB   = 2'b11;

endpackage

// File: rtl/parking_lane_fsm.sv
// One lane: debounce filter on the raw sensor pair plus the entry/exit sequence FSM.
module parking_lane_fsm
  import parking_pkg::*;
#(
  parameter int unsigned FILT_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] raw,
  output logic       entrada,
  output logic       salida,
  output logic       seq_err
);

  localparam int unsigned HIST_W = (FILT_CYC > 1) ? FILT_CYC - 1 : 1;

  logic [1:0]  hist [HIST_W];
  logic [1:0]  filt;
  logic        stable_c;
  lane_state_e state;

  // Raw is accepted only once it matches every sample of the previous FILT_CYC-1 edges
  always_comb begin
    stable_c = 1'b1;
    for (int i = 0; i < int'(FILT_CYC) - 1; i++) begin
      if (hist[i] != raw) stable_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(HIST_W); i++) hist[i] <= S_NONE;
      filt <= S_NONE;
    end else begin
      if (stable_c) filt <= raw;
      hist[0] <= raw;
      for (int i = 1; i < int'(HIST_W); i++) hist[i] <= hist[i-1];
    end
  end

  // Sequence FSM; any two-bit jump in the filtered value is treated as a sequence error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      entrada <= 1'b0;
      salida  <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      entrada <= 1'b0;
      salida  <= 1'b0;
      seq_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          case (filt)
            S_A:     state <= ST_ENT_A;
            S_B:     state <= ST_EXT_B;
            S_AB:    begin state <= ST_RESYNC; seq_err <= 1'b1; end
            default: ;
          endcase
        end
        ST_ENT_A: begin
          case (filt)
            S_AB:    state <= ST_ENT_AB;
            S_NONE:  state <= ST_IDLE;
            S_B:     begin state <= ST_RESYNC; seq_err <= 1'b1; end
            default: ;
          endcase
        end
        ST_ENT_AB: begin
          case (filt)
            S_B:     state <= ST_ENT_B;
            S_A:     state <= ST_ENT_A;
            S_NONE:  begin state <= ST_RESYNC; seq_err <= 1'b1; end
            default: ;
          endcase
        end
        ST_ENT_B: begin
          case (filt)
            S_NONE:  begin state <= ST_IDLE; entrada <= 1'b1; end
            S_AB:    state <= ST_ENT_AB;
            S_A:     begin state <= ST_RESYNC; seq_err <= 1'b1; end
            default: ;
          endcase
        end
        ST_EXT_B: begin
          case (filt)
            S_AB:    state <= ST_EXT_AB;
            S_NONE:  state <= ST_IDLE;
            S_A:     begin state <= ST_RESYNC; seq_err <= 1'b1; end
            default: ;
          endcase
        end
        ST_EXT_AB: begin
          case (filt)
            S_A:     state <= ST_EXT_A;
            S_B:     state <= ST_EXT_B;
            S_NONE:  begin state <= ST_RESYNC; seq_err <= 1'b1; end
            default: ;
          endcase
        end
        ST_EXT_A: begin
          case (filt)
            S_NONE:  begin state <= ST_IDLE; salida <= 1'b1; end
            S_AB:    state <= ST_EXT_AB;
            S_B:     begin state <= ST_RESYNC; seq_err <= 1'b1; end
            default: ;
          endcase
        end
        ST_RESYNC: begin
          if (filt == S_NONE) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_lanes_ctrl.sv
// Multi-lane parking occupancy controller: per-lane sequence detectors feeding a clamped counter.
module parking_lanes_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned N_LANES  = 2,
  parameter int unsigned CAPACITY = 16,
  parameter int unsigned FILT_CYC = 2,
  localparam int unsigned CNT_W   = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*N_LANES-1:0] sensor,
  input  logic                 err_clr,
  output logic [N_LANES-1:0]   entrada,
  output logic [N_LANES-1:0]   salida,
  output logic [N_LANES-1:0]   seq_err,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf,
  output logic                 unf
);

  int               net_c;
  logic             ovf_c;
  logic             unf_c;
  logic [CNT_W-1:0] cnt_next_c;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    parking_lane_fsm #(
      .FILT_CYC (FILT_CYC)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .raw     (sensor[2*g+1:2*g]),
      .entrada (entrada[g]),
      .salida  (salida[g]),
      .seq_err (seq_err[g])
    );
  end

  // Net change from all lanes this cycle, clamped into [0, CAPACITY]
  always_comb begin
    net_c = int'(count);
    for (int i = 0; i < int'(N_LANES); i++) begin
      net_c = net_c + int'(entrada[i]) - int'(salida[i]);
    end
    ovf_c = (net_c > int'(CAPACITY));
    unf_c = (net_c < 0);
    if (ovf_c)      cnt_next_c = CNT_W'(CAPACITY);
    else if (unf_c) cnt_next_c = '0;
    else            cnt_next_c = CNT_W'(net_c);
  end

  // A clamp on the same edge as err_clr keeps its flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= cnt_next_c;
      full  <= (cnt_next_c == CNT_W'(CAPACITY));
      empty <= (cnt_next_c == '0);
      ovf   <= ovf_c | (ovf & ~err_clr);
      unf   <= unf_c | (unf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_parking_lanes_ctrl.sv
// Bench for parking_lanes_ctrl: directed lane sequences plus random sensor walks vs a reference model.
module tb_parking_lanes_ctrl;

  localparam int NL  = 2;
  localparam int CAP = 4;
  localparam int FC  = 2;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*NL-1:0] sensor;
  logic          err_clr;
  logic [NL-1:0] entrada, salida, seq_err;
  logic [CW-1:0] count;
  logic          full, empty, ovf, unf;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: filter window, position along the sensor track, counter
  logic [1:0] m_hist [NL][FC];
  logic [1:0] m_f   [NL];
  logic [1:0] m_cur [NL];
  int         m_dir [NL];
  bit         m_res [NL];
  bit [NL-1:0] m_ent, m_sal, m_err;
  int         m_cnt;
  bit         m_ovf, m_unf;

  parking_lanes_ctrl #(
    .N_LANES  (NL),
    .CAPACITY (CAP),
    .FILT_CYC (FC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sensor  (sensor),
    .err_clr (err_clr),
    .entrada (entrada),
    .salida  (salida),
    .seq_err (seq_err),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      for (int j = 0; j < FC; j++) m_hist[l][j] = 2'b00;
      m_f[l] = 2'b00; m_cur[l] = 2'b00; m_dir[l] = 0; m_res[l] = 1'b0;
    end
    m_ent = '0; m_sal = '0; m_err = '0;
    m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    int  nxt;
    bit  c_ovf, c_unf;
    nxt   = m_cnt + $countones(m_ent) - $countones(m_sal);
    c_ovf = (nxt > CAP);
    c_unf = (nxt < 0);
    m_cnt = c_ovf ? CAP : (c_unf ? 0 : nxt);
    m_ovf = c_ovf || (m_ovf && !err_clr);
    m_unf = c_unf || (m_unf && !err_clr);
    for (int l = 0; l < NL; l++) begin
      logic [1:0] v;
      logic [1:0] r;
      bit         same;
      v = m_f[l];
      m_ent[l] = 1'b0; m_sal[l] = 1'b0; m_err[l] = 1'b0;
      if (m_res[l]) begin
        if (v == 2'b00) begin m_res[l] = 1'b0; m_cur[l] = 2'b00; m_dir[l] = 0; end
      end else if (v != m_cur[l]) begin
        if ($countones(v ^ m_cur[l]) == 2) begin
          m_res[l] = 1'b1; m_err[l] = 1'b1;
        end else if (m_cur[l] == 2'b00) begin
          m_dir[l] = (v == 2'b10) ? 1 : 2; m_cur[l] = v;
        end else if (v == 2'b00) begin
          if (m_dir[l] == 1 && m_cur[l] == 2'b01) m_ent[l] = 1'b1;
          if (m_dir[l] == 2 && m_cur[l] == 2'b10) m_sal[l] = 1'b1;
          m_cur[l] = 2'b00; m_dir[l] = 0;
        end else begin
          m_cur[l] = v;
        end
      end
      r = sensor[2*l +: 2];
      for (int j = FC - 1; j > 0; j--) m_hist[l][j] = m_hist[l][j-1];
      m_hist[l][0] = r;
      same = 1'b1;
      for (int j = 0; j < FC; j++) if (m_hist[l][j] != r) same = 1'b0;
      if (same) m_f[l] = r;
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, "_entrada"}, 32'(entrada), 32'(m_ent));
    chk({where, "_salida"},  32'(salida),  32'(m_sal));
    chk({where, "_seq_err"}, 32'(seq_err), 32'(m_err));
    chk({where, "_count"},   32'(count),   32'(m_cnt));
    chk({where, "_full"},    32'(full),    32'(m_cnt == CAP));
    chk({where, "_empty"},   32'(empty),   32'(m_cnt == 0));
    chk({where, "_ovf"},     32'(ovf),     32'(m_ovf));
    chk({where, "_unf"},     32'(unf),     32'(m_unf));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic drive(input logic [1:0] l0, input logic [1:0] l1, input int n);
    sensor = {l1, l0};
    repeat (n) tick();
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] cur  [NL];
    int         hold [NL];
    rst = 1'b1; sensor = '0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // Lane 0 entry
    drive(2'b10, 2'b00, 3); drive(2'b11, 2'b00, 3); drive(2'b01, 2'b00, 3); drive(2'b00, 2'b00, 5);
    chk("entry_count", 32'(count), 32'd1);
    chk("entry_empty", 32'(empty), 32'd0);

    // Lane 1 exit, then an exit from an empty lot
    drive(2'b00, 2'b01, 3); drive(2'b00, 2'b11, 3); drive(2'b00, 2'b10, 3); drive(2'b00, 2'b00, 5);
    chk("exit_count", 32'(count), 32'd0);
    chk("exit_empty", 32'(empty), 32'd1);
    drive(2'b00, 2'b01, 3); drive(2'b00, 2'b11, 3); drive(2'b00, 2'b10, 3); drive(2'b00, 2'b00, 5);
    chk("underflow_count", 32'(count), 32'd0);
    chk("underflow_unf", 32'(unf), 32'd1);

    // Single-cycle glitch on lane 0, then the entry is completed normally
    drive(2'b10, 2'b00, 3); drive(2'b11, 2'b00, 1); drive(2'b10, 2'b00, 3);
    chk("glitch_seq_err", 32'(seq_err), 32'd0);
    drive(2'b11, 2'b00, 3); drive(2'b01, 2'b00, 3); drive(2'b00, 2'b00, 5);
    chk("glitch_count", 32'(count), 32'd1);

    // Second entry, then simultaneous entry on lane 0 and exit on lane 1
    drive(2'b10, 2'b00, 3); drive(2'b11, 2'b00, 3); drive(2'b01, 2'b00, 3); drive(2'b00, 2'b00, 5);
    drive(2'b10, 2'b01, 3); drive(2'b11, 2'b11, 3); drive(2'b01, 2'b10, 3); drive(2'b00, 2'b00, 5);
    chk("net_zero_count", 32'(count), 32'd2);
    drive(2'b10, 2'b00, 3); drive(2'b11, 2'b00, 3); drive(2'b01, 2'b00, 3); drive(2'b00, 2'b00, 5);
    drive(2'b10, 2'b10, 3); drive(2'b11, 2'b11, 3); drive(2'b01, 2'b01, 3); drive(2'b00, 2'b00, 5);
    chk("overflow_count", 32'(count), 32'd4);
    chk("overflow_full", 32'(full), 32'd1);
    chk("overflow_ovf", 32'(ovf), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr_ovf", 32'(ovf), 32'd0);
    chk("err_clr_unf", 32'(unf), 32'd0);

    // Aborted entry, then an out-of-order sequence into resync
    drive(2'b10, 2'b00, 3); drive(2'b11, 2'b00, 3); drive(2'b10, 2'b00, 3); drive(2'b00, 2'b00, 5);
    chk("abort_count", 32'(count), 32'd4);
    drive(2'b10, 2'b00, 3); drive(2'b01, 2'b00, 3); drive(2'b11, 2'b00, 3); drive(2'b10, 2'b00, 3);
    drive(2'b00, 2'b00, 5);
    chk("resync_count", 32'(count), 32'd4);

    // Reset while lane 0 is mid-entry at count 3
    drive(2'b00, 2'b01, 3); drive(2'b00, 2'b11, 3); drive(2'b00, 2'b10, 3); drive(2'b00, 2'b00, 5);
    chk("pre_reset_count", 32'(count), 32'd3);
    drive(2'b10, 2'b00, 3); drive(2'b11, 2'b00, 3);
    pulse_reset();
    drive(2'b01, 2'b00, 3); drive(2'b00, 2'b00, 5);
    chk("post_reset_count", 32'(count), 32'd0);

    // Random walks: mostly single-bit steps with random hold lengths
    for (int l = 0; l < NL; l++) begin cur[l] = 2'b00; hold[l] = 1; end
    for (int c = 0; c < 1500; c++) begin
      for (int l = 0; l < NL; l++) begin
        hold[l]--;
        if (hold[l] <= 0) begin
          if ($urandom_range(0, 7) != 0) cur[l] = cur[l] ^ 2'($urandom_range(1, 2));
          else                          cur[l] = 2'($urandom_range(0, 3));
          hold[l] = $urandom_range(1, 4);
        end
      end
      sensor  = {cur[1], cur[0]};
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else tick();
    end
    err_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
